// File: rtl/systolic_matmul_engine_pkg.sv
// Shared definitions for the systolic matrix-multiply engine: FSM state
// encoding, default accumulator sizing and packed-vector slice helpers.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Product width plus enough headroom to sum kmax full-scale products.
  function automatic int acc_width_f(input int dw, input int kmax);
    return 2 * dw + $clog2(kmax);
  endfunction

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_width_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB position of element idx inside a packed vector of width-bit elements.
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/systolic_matmul_engine_mac_pe.sv
// One processing element: registers its operands for the right/down
// neighbours and accumulates their product whenever the array advances.
// Assumes ACC_WIDTH is strictly wider than the 2*DATA_WIDTH product.
module mac_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic                  i_mode_signed,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_b,
  output logic [ACC_WIDTH-1:0]  o_acc_next
);
  localparam int PW  = 2 * DATA_WIDTH;
  localparam int PAD = ACC_WIDTH - PW;

  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [PW-1:0]         w_prod_s;
  logic [PW-1:0]         w_prod_u;
  logic [ACC_WIDTH-1:0]  w_prod_ext;
  logic [ACC_WIDTH-1:0]  w_acc_next;

  // Operands are widened to the product width first so the low PW bits are exact.
  assign w_prod_s = $signed({{DATA_WIDTH{i_a[DATA_WIDTH-1]}}, i_a})
                  * $signed({{DATA_WIDTH{i_b[DATA_WIDTH-1]}}, i_b});
  assign w_prod_u = {{DATA_WIDTH{1'b0}}, i_a} * {{DATA_WIDTH{1'b0}}, i_b};
  assign w_prod_ext = {{PAD{i_mode_signed & w_prod_s[PW-1]}},
                       (i_mode_signed ? w_prod_s : w_prod_u)};

  // Next accumulator value is exported so the drain mux can capture a row
  // on the same edge that applies the final product.
  assign w_acc_next = i_clr ? '0 : (i_en ? r_acc + w_prod_ext : r_acc);
  assign o_acc_next = w_acc_next;
  assign o_a = r_a;
  assign o_b = r_b;

  // Operand pipe and accumulator; hold everything when the array does not advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_next;
      if (i_clr) begin
        r_a <= '0;
        r_b <= '0;
      end else if (i_en) begin
        r_a <= i_a;
        r_b <= i_b;
      end
    end
  end

endmodule

// File: rtl/systolic_matmul_engine.sv
// Output-stationary M x N systolic array computing P = A*B with run-time
// depth, internal input skew and valid/ready streaming in and out.
module systolic_matmul_engine
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int M          = 4,
  parameter int N          = 4,
  parameter int K_MAX      = 16,
  parameter int ACC_WIDTH  = acc_width_f(DATA_WIDTH, K_MAX)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(K_MAX+1)-1:0]   k_len,
  input  logic                         mode_signed,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [M*DATA_WIDTH-1:0]      a_col,
  input  logic [N*DATA_WIDTH-1:0]      b_row,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [idx_width_f(M)-1:0]    out_row,
  output logic [N*ACC_WIDTH-1:0]       out_data,
  output logic                         busy,
  output logic                         done
);
  localparam int KW        = $clog2(K_MAX + 1);
  localparam int RW        = idx_width_f(M);
  localparam int FLUSH_LEN = M + N - 2;
  localparam int FW        = $clog2(M + N) + 1;

  state_t                  r_state, w_state_next;
  logic [KW-1:0]           r_k_len, r_k_cnt, w_k_clamped;
  logic                    r_mode;
  logic [FW-1:0]           r_flush_cnt;
  logic                    r_out_valid, r_done;
  logic [RW-1:0]           r_out_row, w_sel_row;
  logic [N*ACC_WIDTH-1:0]  r_out_data, w_sel_data;
  logic                    w_clr, w_in_fire, w_adv, w_out_fire, w_last_row, w_enter_drain;
  logic [DATA_WIDTH-1:0]   w_a_inj  [M];
  logic [DATA_WIDTH-1:0]   w_b_inj  [N];
  logic [DATA_WIDTH-1:0]   w_a_link [M][N+1];
  logic [DATA_WIDTH-1:0]   w_b_link [M+1][N];
  logic [ACC_WIDTH-1:0]    w_acc_next [M][N];

  assign w_k_clamped   = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  assign w_clr         = (r_state == IDLE) && start;
  assign w_in_fire     = (r_state == LOAD) && in_valid;
  // Bubbles in LOAD freeze the whole array, skew lines included.
  assign w_adv         = w_in_fire || (r_state == FLUSH);
  assign w_out_fire    = (r_state == DRAIN) && r_out_valid && out_ready;
  assign w_last_row    = (r_out_row == RW'(M - 1));
  assign w_enter_drain = (r_state != DRAIN) && (w_state_next == DRAIN);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode and state-derived handshake outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b1;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = (w_k_clamped == '0) ? DRAIN : LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (r_k_cnt == r_k_len - KW'(1)))
          w_state_next = (FLUSH_LEN == 0) ? DRAIN : FLUSH;
      end
      FLUSH:   if (r_flush_cnt == FW'(FLUSH_LEN - 1)) w_state_next = DRAIN;
      DRAIN:   if (w_out_fire && w_last_row) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Job parameters and the slice / flush counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_k_len     <= '0;
      r_mode      <= 1'b0;
      r_k_cnt     <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_clr) begin
        r_k_len <= w_k_clamped;
        r_mode  <= mode_signed;
        r_k_cnt <= '0;
      end else if (w_in_fire) begin
        r_k_cnt <= r_k_cnt + KW'(1);
      end
      if (r_state == FLUSH) r_flush_cnt <= r_flush_cnt + FW'(1);
      else                  r_flush_cnt <= '0;
    end
  end

  // Row i of A enters the array i advances late; zeros are injected while flushing.
  genvar gi, gj;
  for (gi = 0; gi < M; gi++) begin : g_a_skew
    assign w_a_inj[gi] = (r_state == LOAD) ?
                         a_col[slice_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] : '0;
    if (gi == 0) begin : g_direct
      assign w_a_link[gi][0] = w_a_inj[gi];
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] r_line [gi];
      // Shift register of depth gi, moving only when the array advances.
      always_ff @(posedge clk) begin
        if (!reset || w_clr) begin
          for (int s = 0; s < gi; s++) r_line[s] <= '0;
        end else if (w_adv) begin
          r_line[0] <= w_a_inj[gi];
          for (int s = 1; s < gi; s++) r_line[s] <= r_line[s-1];
        end
      end
      assign w_a_link[gi][0] = r_line[gi-1];
    end
  end

  // Column j of B enters the array j advances late.
  for (gj = 0; gj < N; gj++) begin : g_b_skew
    assign w_b_inj[gj] = (r_state == LOAD) ?
                         b_row[slice_lsb(gj, DATA_WIDTH) +: DATA_WIDTH] : '0;
    if (gj == 0) begin : g_direct
      assign w_b_link[0][gj] = w_b_inj[gj];
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] r_line [gj];
      // Shift register of depth gj, moving only when the array advances.
      always_ff @(posedge clk) begin
        if (!reset || w_clr) begin
          for (int s = 0; s < gj; s++) r_line[s] <= '0;
        end else if (w_adv) begin
          r_line[0] <= w_b_inj[gj];
          for (int s = 1; s < gj; s++) r_line[s] <= r_line[s-1];
        end
      end
      assign w_b_link[0][gj] = r_line[gj-1];
    end
  end

  // PE grid: a moves right, b moves down, P[i][j] stays in PE(i,j).
  for (gi = 0; gi < M; gi++) begin : g_row
    for (gj = 0; gj < N; gj++) begin : g_col
      mac_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk           (clk),
        .reset         (reset),
        .i_en          (w_adv),
        .i_clr         (w_clr),
        .i_mode_signed (r_mode),
        .i_a           (w_a_link[gi][gj]),
        .i_b           (w_b_link[gi][gj]),
        .o_a           (w_a_link[gi][gj+1]),
        .o_b           (w_b_link[gi+1][gj]),
        .o_acc_next    (w_acc_next[gi][gj])
      );
    end
  end

  // Row mux: row 0 on entry to DRAIN, otherwise the row after the one leaving.
  assign w_sel_row = w_enter_drain ? '0 : r_out_row + RW'(1);
  always_comb begin
    w_sel_data = '0;
    for (int j = 0; j < N; j++)
      w_sel_data[j*ACC_WIDTH +: ACC_WIDTH] = w_acc_next[w_sel_row][j];
  end

  // Registered result port; row and data hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_out_fire && w_last_row;
      if (w_enter_drain) begin
        r_out_valid <= 1'b1;
        r_out_row   <= '0;
        r_out_data  <= w_sel_data;
      end else if (w_out_fire) begin
        if (w_last_row) begin
          r_out_valid <= 1'b0;
        end else begin
          r_out_row  <= w_sel_row;
          r_out_data <= w_sel_data;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_row   = r_out_row;
  assign out_data  = r_out_data;
  assign done      = r_done;

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Directed-sequence bench with randomized operands for the systolic engine;
// expected results come from a plain sum-of-products model of P = A*B.
module tb_systolic_matmul_engine;
  localparam int DW = 8;
  localparam int M  = 4;
  localparam int N  = 4;
  localparam int KM = 16;
  localparam int AW = 20;

  logic              clk = 1'b0;
  logic              reset, start, mode_signed, in_valid, out_ready;
  logic [4:0]        k_len;
  logic              in_ready, out_valid, busy, done;
  logic [M*DW-1:0]   a_col;
  logic [N*DW-1:0]   b_row;
  logic [1:0]        out_row;
  logic [N*AW-1:0]   out_data;

  always #5 clk = ~clk;

  systolic_matmul_engine dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len),
    .mode_signed(mode_signed), .in_valid(in_valid), .in_ready(in_ready),
    .a_col(a_col), .b_row(b_row), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_data(out_data), .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_fire = 0;
  logic [DW-1:0]   ma [M][KM];
  logic [DW-1:0]   mb [KM][N];
  logic [N*AW-1:0] exp_rows [M];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // P[i][j] = sum_k A[i][k]*B[k][j], reduced modulo 2^AW.
  function automatic void build_model(input int k, input bit sgn);
    int kk;
    longint s, av, bv;
    kk = (k > KM) ? KM : k;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int t = 0; t < kk; t++) begin
          av = sgn ? longint'($signed(ma[i][t])) : longint'(ma[i][t]);
          bv = sgn ? longint'($signed(mb[t][j])) : longint'(mb[t][j]);
          s += av * bv;
        end
        exp_rows[i][j*AW +: AW] = s[AW-1:0];
      end
  endfunction

  task automatic fill_random();
    for (int i = 0; i < M; i++)
      for (int t = 0; t < KM; t++) ma[i][t] = DW'($urandom);
    for (int t = 0; t < KM; t++)
      for (int j = 0; j < N; j++) mb[t][j] = DW'($urandom);
  endtask

  task automatic start_job(input int k, input bit sgn);
    @(negedge clk);
    start = 1'b1;
    k_len = 5'(k);
    mode_signed = sgn;
    @(negedge clk);
    start = 1'b0;
    k_len = 5'($urandom);
    mode_signed = ~sgn;
    $display("job start k_len=%0d signed=%0d", k, sgn);
  endtask

  task automatic feed(input int k, input int pct, input bit poke_start);
    int idx;
    int guard;
    bit v;
    idx = 0;
    guard = 0;
    while (idx < k && guard < 1000) begin
      v = ($urandom_range(99) < 32'(pct));
      in_valid = v;
      if (v) begin
        for (int i = 0; i < M; i++) a_col[i*DW +: DW] = ma[i][idx];
        for (int j = 0; j < N; j++) b_row[j*DW +: DW] = mb[idx][j];
      end else begin
        a_col = $urandom;
        b_row = $urandom;
      end
      if (poke_start) begin
        start = 1'b1;
        k_len = 5'd2;
      end
      if (v && in_ready) begin
        last_fire = cyc;
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("beats_accepted", 128'(idx), 128'(k));
  endtask

  task automatic collect(input int stall_row, input int exp_lat);
    int guard;
    guard = 0;
    out_ready = 1'b1;
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("out_valid_seen", 128'(out_valid), 128'(1));
    if (exp_lat >= 0) check("first_valid_latency", 128'(cyc - last_fire), 128'(exp_lat));
    for (int r = 0; r < M; r++) begin
      $display("row %0d valid=%0d data=%h", out_row, out_valid, out_data);
      check($sformatf("row%0d_valid", r), 128'(out_valid), 128'(1));
      check($sformatf("row%0d_index", r), 128'(out_row), 128'(r));
      check($sformatf("row%0d_data", r), 128'(out_data), 128'(exp_rows[r]));
      if (r == stall_row) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", 128'(out_valid), 128'(1));
          check("stall_row", 128'(out_row), 128'(r));
          check("stall_data", 128'(out_data), 128'(exp_rows[r]));
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    check("done_pulse", 128'(done), 128'(1));
    check("busy_low_at_done", 128'(busy), 128'(0));
    check("valid_low_after_job", 128'(out_valid), 128'(0));
    @(negedge clk);
    check("done_one_cycle", 128'(done), 128'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int done_seen;
    reset = 1'b0; start = 1'b0; mode_signed = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1; k_len = 5'd0; a_col = $urandom; b_row = $urandom;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_out_row", 128'(out_row), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    reset = 1'b1;
    in_valid = 1'b0;

    // Identity A times counting B: rows reproduce B
    for (int i = 0; i < M; i++)
      for (int t = 0; t < KM; t++) ma[i][t] = (i == t) ? 8'd1 : 8'd0;
    for (int t = 0; t < KM; t++)
      for (int j = 0; j < N; j++) mb[t][j] = DW'(t * 4 + j);
    build_model(4, 1'b0);
    start_job(4, 1'b0);
    check("in_ready_after_start", 128'(in_ready), 128'(1));
    check("busy_after_start", 128'(busy), 128'(1));
    feed(4, 100, 1'b0);
    collect(-1, M + N - 1);

    // Random unsigned, full depth, with bubbles then without
    fill_random();
    build_model(16, 1'b0);
    start_job(16, 1'b0);
    feed(16, 50, 1'b0);
    collect(-1, -1);
    start_job(16, 1'b0);
    feed(16, 100, 1'b0);
    collect(-1, M + N - 1);

    // Signed extreme: (-128)*(-128)*16 = 262144
    for (int i = 0; i < M; i++)
      for (int t = 0; t < KM; t++) ma[i][t] = 8'h80;
    for (int t = 0; t < KM; t++)
      for (int j = 0; j < N; j++) mb[t][j] = 8'h80;
    build_model(16, 1'b1);
    start_job(16, 1'b1);
    feed(16, 100, 1'b0);
    collect(-1, M + N - 1);

    // Zero depth: no operand beats, all-zero rows
    build_model(0, 1'b0);
    start_job(0, 1'b0);
    check("k0_in_ready", 128'(in_ready), 128'(0));
    collect(-1, -1);

    // Signed random depth with a 5-cycle stall on row 2
    fill_random();
    k = $urandom_range(16, 1);
    build_model(k, 1'b1);
    start_job(k, 1'b1);
    feed(k, 70, 1'b0);
    collect(2, -1);

    // Oversized k_len is clamped to K_MAX
    fill_random();
    build_model(16, 1'b0);
    start_job(20, 1'b0);
    feed(16, 100, 1'b0);
    collect(-1, M + N - 1);

    // Abort during FLUSH with reset
    fill_random();
    start_job(8, 1'b0);
    feed(8, 100, 1'b0);
    @(negedge clk);
    check("abort_in_flush_busy", 128'(busy), 128'(1));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_in_ready", 128'(in_ready), 128'(0));
    check("abort_out_valid", 128'(out_valid), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_out_row", 128'(out_row), 128'(0));
    check("abort_out_data", 128'(out_data), 128'(0));
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", 128'(done_seen), 128'(0));

    // New job after abort, with start pulses while busy
    fill_random();
    k = $urandom_range(16, 3);
    build_model(k, 1'b1);
    start_job(k, 1'b1);
    feed(k, 60, 1'b1);
    collect(-1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_matmul_engine.md
# systolic_matmul_engine

Parametrised output-stationary systolic matrix-multiply engine computing P = A·B for an M×K by K×N operand pair, with run-time depth K (1..K_MAX), internal input skewing, wide accumulators and valid/ready streaming on both sides. It is the next-generation compute core of the TPU datapath. Operands stream in one k-slice per beat and results drain out one row per handshake, so the block sits directly between the operand fetch buffers and the result writeback.

## Interface
- DATA_WIDTH, 8, operand element width
- M, 4, PE rows (rows of A / P)
- N, 4, PE columns (columns of B / P)
- K_MAX, 16, maximum inner dimension
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(K_MAX), accumulator / result element width
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-low
- start  in  1  begin a job; accepted only in IDLE
- k_len  in  $clog2(K_MAX+1)  inner dimension, sampled with start
- mode_signed  in  1  1 = two's-complement operands, sampled with start
- in_valid  in  1  operand beat valid
- in_ready  out  1  engine accepts beat
- a_col  in  M*DATA_WIDTH  A[i][k], element i at [i*DATA_WIDTH +: DATA_WIDTH]
- b_row  in  N*DATA_WIDTH  B[k][j], element j at [j*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  result row valid
- out_ready  in  1  downstream accepts row
- out_row  out  $clog2(M) (min 1)  row index of out_data
- out_data  out  N*ACC_WIDTH  P[out_row][j] at [j*ACC_WIDTH +: ACC_WIDTH]
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after last row accepted

## Operation
- FSM: IDLE → LOAD → FLUSH → DRAIN → IDLE.
- IDLE: start=1 latches k_len and mode_signed, clears all accumulators and skew registers. Next state is LOAD, or DRAIN if k_len=0, which drains all-zero rows.
- LOAD: in_ready=1. Each fire (in_valid&in_ready) supplies k-slice k=0,1,… in order. After k_len fires, go to FLUSH, or straight to DRAIN when M+N-2=0.
- FLUSH: runs M+N-2 cycles with zeros injected, then DRAIN.
- Array advance: the whole array, including skew delay lines and PE operand pipes, shifts only on a LOAD fire or a FLUSH cycle. Without a fire in LOAD the array holds state, so bubbles never corrupt results.
- Skew: row i of a_col is delayed i advances; column j of b_row is delayed j advances. PE(i,j) multiplies slice k on advance k+i+j.
- PE: acc += a·b, where a passes right and b passes down with one register each. Product is 2*DATA_WIDTH, sign- or zero-extended to ACC_WIDTH per mode_signed.
- Overflow: accumulation wraps modulo 2^ACC_WIDTH. The default width cannot overflow for k_len≤K_MAX.
- DRAIN: presents row r=0..M-1 in order; out_row=r. Row and out_data are held stable while out_valid&!out_ready. Advances on out_valid&out_ready. The fire of row M-1 goes to IDLE and pulses done the next cycle.
- start outside IDLE is ignored; k_len>K_MAX is clamped to K_MAX.
- Reset (reset=0 at a clock edge): state IDLE; in_ready, out_valid, busy, done, out_row, out_data, accumulators and skew registers all 0. Reset in any state aborts the job with no done.

## Timing
- start accepted at cycle t → in_ready=1 from t+1.
- Last LOAD fire at cycle u → first out_valid at u+M+N-1 with no stalls (M+N-2 flush cycles plus 1 transfer cycle).
- Fully streamed job: start to last row out = 1 + k_len + (M+N-2) + M cycles, with out_ready held at 1.
- out_valid is registered; out_data is registered from the accumulator row mux.
- done is high exactly one cycle; busy falls in the same cycle done rises.

## Structure
- systolic_pkg holds the state enum (IDLE, LOAD, FLUSH, DRAIN), the default ACC_WIDTH function, and the row/column slice helper functions.
- Sub-module mac_pe: a single PE with operand registers, enable, clear, mode_signed, and accumulator. It is instantiated M×N by generate.
- Top level holds the FSM, k/flush/row counters, skew delay lines and the drain mux.

## Test plan
- A=identity, B[k][j]=k*4+j, k_len=4, unsigned, no stalls → rows equal B. First out_valid 7 cycles after last fire; done after 4 rows.
- Random unsigned A, B, k_len=16, in_valid toggling 50% → P matches reference model exactly, with results independent of bubble pattern.
- mode_signed=1, all A=-128, all B=-128, k_len=16 → every P element = 262144, with no wrap at ACC_WIDTH=20.
- k_len=0 → no in_ready, 4 zero rows, done pulse.
- out_ready low for 5 cycles on row 2 → out_row=2 and out_data stable while stalled; row order 0,1,2,3 is preserved.
- reset=0 during FLUSH, then start with a new job → all outputs 0 after reset, no done for the aborted job, new job correct; start pulses while busy are ignored.
